// File: rtl/issue_ctrl_pkg.sv
// Shared core definitions: decode operation and operand selects, issue classes,
// divider FSM encoding and default functional-unit latencies.
package issue_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_COPY1 = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    OPSEL_RS   = 2'd0,
    OPSEL_IMM  = 2'd1,
    OPSEL_PC   = 2'd2,
    OPSEL_ZERO = 2'd3
  } opsel_e;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_DIV  = 2'd3
  } iclass_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int DEF_LOAD_LAT = 2;
  localparam int DEF_MUL_LAT  = 3;
  localparam int DEF_DIV_LAT  = 34;
  localparam int DEF_ALU_LAT  = 1;

  localparam int CNT_W  = 6;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  function automatic logic [CNT_W-1:0] class_lat(input logic [1:0] cls,
                                                 input int alu_lat,
                                                 input int load_lat,
                                                 input int mul_lat,
                                                 input int div_lat);
    logic [CNT_W-1:0] lat;
    case (cls)
      CLS_LOAD: lat = CNT_W'(load_lat);
      CLS_MUL:  lat = CNT_W'(mul_lat);
      CLS_DIV:  lat = CNT_W'(div_lat);
      default:  lat = CNT_W'(alu_lat);
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register countdown of cycles until a pending result is written back.
// x0 has no storage; a new issue overrides the countdown of the same entry.
module issue_scoreboard
  import issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_set_en,
  input  logic [REG_AW-1:0] i_set_addr,
  input  logic [CNT_W-1:0]  i_set_val,
  input  logic [REG_AW-1:0] i_rs1_addr,
  input  logic [REG_AW-1:0] i_rs2_addr,
  input  logic [REG_AW-1:0] i_rd_addr,
  output logic [CNT_W-1:0]  o_rs1_cnt,
  output logic [CNT_W-1:0]  o_rs2_cnt,
  output logic [CNT_W-1:0]  o_rd_cnt
);

  logic [CNT_W-1:0] w_cnt [NREGS];

  assign w_cnt[0] = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_ent
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
        r_cnt <= '0;
      end else if (i_set_en && (i_set_addr == REG_AW'(g))) begin
        r_cnt <= i_set_val;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end

    assign w_cnt[g] = r_cnt;
  end

  assign o_rs1_cnt = w_cnt[i_rs1_addr];
  assign o_rs2_cnt = w_cnt[i_rs2_addr];
  assign o_rd_cnt  = w_cnt[i_rd_addr];

endmodule

// File: rtl/issue_ctrl.sv
// Decode-stage issue control: RAW/WAW/structural/writeback-port hazard stalls,
// fetch flush on taken branches, and the iterative divider occupancy FSM.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int MUL_LAT  = DEF_MUL_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int ALU_LAT  = DEF_ALU_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [1:0]        id_class,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_rf_w_en,
  input  logic              id_branch_taken,
  output logic              stall_decode,
  output logic              flush_fetch,
  output logic              div_start,
  output logic              div_busy
);

  logic [CNT_W-1:0] w_lat;
  logic [CNT_W-1:0] w_rs1_cnt;
  logic [CNT_W-1:0] w_rs2_cnt;
  logic [CNT_W-1:0] w_rd_cnt;
  logic             w_rd_nz;
  logic             w_is_div;
  logic             w_raw;
  logic             w_waw;
  logic             w_struct;
  logic             w_wb;
  logic             w_issue;
  logic             w_set_en;
  logic             w_div_go;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_div_cnt;
  logic             r_div_start;

  assign w_lat    = class_lat(id_class, ALU_LAT, LOAD_LAT, MUL_LAT, DIV_LAT);
  assign w_rd_nz  = (id_rd_addr != '0);
  assign w_is_div = (id_class == CLS_DIV);

  issue_scoreboard u_sb (
    .clk        (clk),
    .i_rst      (reset),
    .i_set_en   (w_set_en),
    .i_set_addr (id_rd_addr),
    .i_set_val  (w_lat),
    .i_rs1_addr (id_rs1_addr),
    .i_rs2_addr (id_rs2_addr),
    .i_rd_addr  (id_rd_addr),
    .o_rs1_cnt  (w_rs1_cnt),
    .o_rs2_cnt  (w_rs2_cnt),
    .o_rd_cnt   (w_rd_cnt)
  );

  assign w_raw = (id_rs1_used && (w_rs1_cnt != '0)) ||
                 (id_rs2_used && (w_rs2_cnt != '0));

  assign w_waw = id_rf_w_en && w_rd_nz && (w_rd_cnt > w_lat);

  // The divider frees up on the edge where div_cnt goes 1->0, so a waiting
  // DIV is accepted in that same cycle.
  assign w_struct = w_is_div && (r_state == ST_BUSY) && (r_div_cnt != CNT_W'(1));

  // A non-DIV result landing on the same edge as the divide result would
  // need a second register-file write port.
  assign w_wb = id_rf_w_en && !w_is_div && (r_state == ST_BUSY) &&
                (r_div_cnt == (w_lat + CNT_W'(1)));

  assign stall_decode = id_valid && (w_raw || w_waw || w_struct || w_wb);
  assign w_issue      = id_valid && !stall_decode;
  assign flush_fetch  = w_issue && id_branch_taken;
  assign w_set_en     = w_issue && id_rf_w_en && w_rd_nz;
  assign w_div_go     = w_issue && w_is_div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_div_cnt   <= '0;
      r_div_start <= 1'b0;
    end else begin
      r_div_start <= w_div_go;
      if (w_div_go) begin
        r_state   <= ST_BUSY;
        r_div_cnt <= CNT_W'(DIV_LAT);
      end else if (r_state == ST_BUSY) begin
        r_div_cnt <= r_div_cnt - CNT_W'(1);
        if (r_div_cnt == CNT_W'(1)) begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

  assign div_start = r_div_start;
  assign div_busy  = (r_state == ST_BUSY);

  a_start_busy: assert property (@(posedge clk) disable iff (reset) div_start |-> div_busy);

endmodule
